// File: rtl/bus_cycle_sequencer_if.sv
// Bus-cycle sequencer bundle: core request/ack handshake plus the external bus side
// (phase clock, direction, address, write data, RDY and read data).
interface bus_cycle_sequencer_if #(
  parameter int unsigned AW = 16
);
  // Core request side
  logic          req;
  logic          we;
  logic [AW-1:0] addr_in;
  logic [7:0]    wdata;
  logic          ack;
  logic [7:0]    rdata;
  // External bus side
  logic          rdy;
  logic [7:0]    bus_rdata;
  logic          phi2;
  logic          rwb;
  logic [AW-1:0] addr;
  logic [7:0]    db_wdata;
  logic          latch_en;

  // Everything the sequencer consumes is driven by the master side
  modport master (
    output req, we, addr_in, wdata, rdy, bus_rdata,
    input  ack, rdata, phi2, rwb, addr, db_wdata, latch_en
  );

  modport slave (
    input  req, we, addr_in, wdata, rdy, bus_rdata,
    output ack, rdata, phi2, rwb, addr, db_wdata, latch_en
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// 65C02 bus-cycle sequencer: free-running phi2 from fclk, one request per bus cycle,
// RDY wait-state stretching, read-data capture at the end of phi2 with a one-fclk ack.
module bus_cycle_sequencer #(
  parameter int unsigned HALF = 2,
  parameter int unsigned AW   = 16
) (
  input  logic                   fclk,
  input  logic                   resb,
  bus_cycle_sequencer_if.slave   bus
);

  localparam int unsigned CW = $clog2(HALF) + 1;
  localparam logic [CW-1:0] CntMax = CW'(HALF - 1);

  typedef enum logic {StPhi1, StPhi2} phase_e;

  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Set at capture, cleared on completion. Still set during PHI1 means a stretched
  // cycle is pending and gets re-run without re-sampling the request.
  logic          live_q, live_d;
  logic          rwb_q, rwb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    db_wdata_q, db_wdata_d;
  logic          ack_q, ack_d;
  logic [7:0]    rdata_q, rdata_d;

  logic cycle_start;
  logic cycle_end;

  assign cycle_start = (phase_q == StPhi1) && (cnt_q == '0);
  assign cycle_end   = (phase_q == StPhi2) && (cnt_q == CntMax);

  // State register; async reset aborts any cycle in flight
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      phase_q    <= StPhi1;
      cnt_q      <= '0;
      live_q     <= 1'b0;
      rwb_q      <= 1'b1;
      addr_q     <= '0;
      db_wdata_q <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      live_q     <= live_d;
      rwb_q      <= rwb_d;
      addr_q     <= addr_d;
      db_wdata_q <= db_wdata_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  // Phase timing, request capture and completion
  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    live_d     = live_q;
    rwb_d      = rwb_q;
    addr_d     = addr_q;
    db_wdata_d = db_wdata_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;

    if (cnt_q == CntMax) begin
      cnt_d   = '0;
      phase_d = (phase_q == StPhi1) ? StPhi2 : StPhi1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A pending stretched cycle keeps addr/rwb/db_wdata as they are
    if (cycle_start && !live_q) begin
      if (bus.req) begin
        live_d     = 1'b1;
        addr_d     = bus.addr_in;
        rwb_d      = ~bus.we;
        db_wdata_d = bus.wdata;
      end else begin
        rwb_d = 1'b1;
      end
    end

    if (cycle_end && live_q && bus.rdy) begin
      ack_d  = 1'b1;
      live_d = 1'b0;
      if (rwb_q) begin
        rdata_d = bus.bus_rdata;
      end
    end
  end

  assign bus.phi2     = (phase_q == StPhi2);
  assign bus.latch_en = live_q && (phase_q == StPhi2);
  assign bus.rwb      = rwb_q;
  assign bus.addr     = addr_q;
  assign bus.db_wdata = db_wdata_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: three instances (HALF = 2, 1, 3) run in lockstep, each with
// its own core that presents queued transactions and holds them until ack. A bus-cycle model
// derived from position-in-cycle arithmetic predicts every output on every fclk.
module tb_bus_cycle_sequencer;

  localparam int NI = 3;
  localparam int HV [NI] = '{2, 1, 3};

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  data;
    int          stall;
    int          gap;
  } txn_t;

  logic fclk = 1'b0;
  logic resb = 1'b1;
  always #5 fclk = ~fclk;

  logic        req_a [NI];
  logic        we_a [NI];
  logic        rdy_a [NI];
  logic [15:0] addr_in_a [NI];
  logic [7:0]  wdata_a [NI];
  logic [7:0]  bus_rdata_a [NI];
  logic        ack_a [NI];
  logic        phi2_a [NI];
  logic        rwb_a [NI];
  logic        latch_a [NI];
  logic [15:0] addr_a [NI];
  logic [7:0]  dbw_a [NI];
  logic [7:0]  rdata_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_cycle_sequencer_if #(.AW(16)) bif ();
    assign bif.req       = req_a[g];
    assign bif.we        = we_a[g];
    assign bif.addr_in   = addr_in_a[g];
    assign bif.wdata     = wdata_a[g];
    assign bif.rdy       = rdy_a[g];
    assign bif.bus_rdata = bus_rdata_a[g];
    assign ack_a[g]      = bif.ack;
    assign phi2_a[g]     = bif.phi2;
    assign rwb_a[g]      = bif.rwb;
    assign latch_a[g]    = bif.latch_en;
    assign addr_a[g]     = bif.addr;
    assign dbw_a[g]      = bif.db_wdata;
    assign rdata_a[g]    = bif.rdata;

    bus_cycle_sequencer #(.HALF(HV[g]), .AW(16)) u_dut (
      .fclk (fclk),
      .resb (resb),
      .bus  (bif.slave)
    );
  end

  // Reference model: expected state for the current fclk n
  bit          busy [NI];
  logic        m_rwb [NI];
  logic [15:0] m_addr [NI];
  logic [7:0]  m_wd [NI];
  logic [7:0]  m_rd [NI];
  logic        m_ack [NI];
  int          stalls [NI];

  // Core side
  txn_t tl[$];
  int   head [NI];
  int   wait_cnt [NI];
  bit   active [NI];
  int   ack_n [NI];
  int   prev_ack [NI];

  int n;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s HALF=%0d n=%0d observed %0h expected %0h", tag, HV[k], n, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                      input logic [7:0] data, input int stall, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.data = data; t.stall = stall; t.gap = gap;
    tl.push_back(t);
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      logic ph;
      ph = (n % (2 * HV[k])) >= HV[k];
      chk("phi2", k, phi2_a[k], ph);
      chk("latch_en", k, latch_a[k], busy[k] && ph);
      chk("rwb", k, rwb_a[k], m_rwb[k]);
      chk("addr", k, addr_a[k], m_addr[k]);
      chk("db_wdata", k, dbw_a[k], m_wd[k]);
      chk("ack", k, ack_a[k], m_ack[k]);
      chk("rdata", k, rdata_a[k], m_rd[k]);
    end
  endtask

  // Apply the bus-cycle rules to the inputs sampled at the edge ending fclk n
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      int p;
      p = n % (2 * HV[k]);
      m_ack[k] = 1'b0;
      if (p == 0 && !busy[k]) begin
        if (req_a[k]) begin
          busy[k] = 1'b1;
          m_addr[k] = addr_in_a[k];
          m_rwb[k] = ~we_a[k];
          m_wd[k] = wdata_a[k];
        end else begin
          m_rwb[k] = 1'b1;
        end
      end
      if (p == 2 * HV[k] - 1 && busy[k]) begin
        if (rdy_a[k]) begin
          m_ack[k] = 1'b1;
          busy[k] = 1'b0;
          if (m_rwb[k]) m_rd[k] = bus_rdata_a[k];
        end else begin
          stalls[k]++;
        end
      end
    end
  endtask

  task automatic step();
    for (int k = 0; k < NI; k++) begin
      int unsigned r;
      int p;
      p = n % (2 * HV[k]);
      if (!active[k] && head[k] < tl.size()) begin
        if (wait_cnt[k] > 0) wait_cnt[k]--;
        else begin
          active[k] = 1'b1;
          stalls[k] = 0;
        end
      end
      r = $urandom;
      if (active[k]) begin
        req_a[k] = 1'b1;
        we_a[k] = tl[head[k]].we;
        addr_in_a[k] = tl[head[k]].addr;
        wdata_a[k] = tl[head[k]].wdata;
      end else begin
        req_a[k] = 1'b0;
        we_a[k] = r[0];
        addr_in_a[k] = r[16:1];
        wdata_a[k] = r[24:17];
      end
      r = $urandom;
      if (active[k] && p == 2 * HV[k] - 1) rdy_a[k] = (stalls[k] >= tl[head[k]].stall);
      else rdy_a[k] = r[0];
      if (active[k] && p == 2 * HV[k] - 1 && rdy_a[k]) bus_rdata_a[k] = tl[head[k]].data;
      else bus_rdata_a[k] = r[8:1];
    end
    model_edge();
    @(posedge fclk);
    #1;
    n++;
    check_all();
    for (int k = 0; k < NI; k++) begin
      if (active[k] && ack_a[k] === 1'b1) begin
        active[k] = 1'b0;
        prev_ack[k] = ack_n[k];
        ack_n[k] = n;
        head[k]++;
        wait_cnt[k] = (head[k] < tl.size()) ? tl[head[k]].gap : 0;
      end
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = 1'b1;
    for (int k = 0; k < NI; k++) if (active[k] || head[k] < tl.size()) d = 1'b0;
    return d;
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    while (!all_done() && guard < 3000) begin
      step();
      guard++;
    end
    chk("drain_done", 0, all_done(), 1);
  endtask

  task automatic apply_reset();
    resb = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_a[k] = 1'b0; we_a[k] = 1'b0; addr_in_a[k] = '0; wdata_a[k] = '0;
      rdy_a[k] = 1'b1; bus_rdata_a[k] = '0;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_rwb", k, rwb_a[k], 1);
      chk("rst_phi2", k, phi2_a[k], 0);
      chk("rst_addr", k, addr_a[k], 0);
      chk("rst_ack", k, ack_a[k], 0);
      chk("rst_latch", k, latch_a[k], 0);
      chk("rst_dbw", k, dbw_a[k], 0);
      chk("rst_rdata", k, rdata_a[k], 0);
    end
    repeat (2) @(posedge fclk);
    @(negedge fclk);
    for (int k = 0; k < NI; k++) begin
      busy[k] = 1'b0; m_rwb[k] = 1'b1; m_addr[k] = '0; m_wd[k] = '0; m_rd[k] = '0;
      m_ack[k] = 1'b0; stalls[k] = 0; head[k] = 0; wait_cnt[k] = 0; active[k] = 1'b0;
      ack_n[k] = 0; prev_ack[k] = 0;
    end
    tl.delete();
    resb = 1'b1;
    n = 0;
    check_all();
  endtask

  initial begin
    int unsigned r;
    int guard;
    #2;
    apply_reset();

    // Idle bus cycles: free-running phi2, no ack, rwb high
    for (int i = 0; i < 12; i++) step();

    // Single read
    push(1'b0, 16'hFFFC, 8'h00, 8'hA5, 0, 0);
    drain();
    for (int k = 0; k < NI; k++) chk("read_rdata", k, rdata_a[k], 8'hA5);

    // Single write leaves rdata alone
    push(1'b1, 16'h0200, 8'h3C, 8'hEE, 0, 0);
    drain();
    for (int k = 0; k < NI; k++) chk("write_keeps_rdata", k, rdata_a[k], 8'hA5);

    // Read stretched by two RDY-low cycle ends
    push(1'b0, 16'h1234, 8'h00, 8'h5A, 2, 1);
    drain();
    for (int k = 0; k < NI; k++) chk("stall_rdata", k, rdata_a[k], 8'h5A);

    // Back-to-back reads with req held
    push(1'b0, 16'h0010, 8'h00, 8'h11, 0, 0);
    push(1'b0, 16'h0011, 8'h00, 8'h22, 0, 0);
    drain();
    for (int k = 0; k < NI; k++) begin
      chk("b2b_ack_gap", k, ack_n[k] - prev_ack[k], 2 * HV[k]);
      chk("b2b_rdata", k, rdata_a[k], 8'h22);
    end

    // Randomised traffic: mixed reads/writes, stalls, gaps, mid-cycle req rises
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      push(r[0], r[16:1], r[24:17], r[31:24], int'($urandom_range(0, 2)),
           int'($urandom_range(0, 3)));
    end
    drain();

    // Reset during PHI2 of a live write on the HALF=2 instance
    push(1'b1, 16'h0BEE, 8'hC3, 8'h00, 0, 0);
    guard = 0;
    while (!(busy[0] && (n % 4) >= 2) && guard < 40) begin
      step();
      guard++;
    end
    chk("reach_write_phi2", 0, busy[0] && (n % 4) >= 2, 1);
    #2;
    apply_reset();

    // Recovery after reset
    push(1'b0, 16'h4444, 8'h00, 8'h77, 0, 0);
    drain();
    for (int k = 0; k < NI; k++) chk("post_reset_read", k, rdata_a[k], 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
